// File: rtl/ingress_packetizer_if.sv
// ingress_packetizer_if: client stream, switch write framing and status for one port.
// The tx_pkt_cnt signal exists only when PKTZ_STAT_EN is defined.
interface ingress_packetizer_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_last;
    logic [1:0]  in_dest;
    logic [1:0]  in_prio;
    logic        pause;
    logic        wr_sop;
    logic        wr_vld;
    logic [15:0] wr_data;
    logic        wr_eop;
    logic [15:0] drop_cnt;
`ifdef PKTZ_STAT_EN
    logic [15:0] tx_pkt_cnt;
`endif

    // Client and switch side: drives the word stream and pause, observes framing.
    modport master (
        output in_valid, in_data, in_last, in_dest, in_prio, pause,
`ifdef PKTZ_STAT_EN
        input  tx_pkt_cnt,
`endif
        input  in_ready, wr_sop, wr_vld, wr_data, wr_eop, drop_cnt
    );

    // Packetizer side.
    modport slave (
        input  in_valid, in_data, in_last, in_dest, in_prio, pause,
`ifdef PKTZ_STAT_EN
        output tx_pkt_cnt,
`endif
        output in_ready, wr_sop, wr_vld, wr_data, wr_eop, drop_cnt
    );
endinterface

// File: rtl/ingress_packetizer.sv
// ingress_packetizer: store-and-forward feeder for the hydra switch write port.
// Buffers each client packet until its length is known, then emits
// sop / header + payload / eop, honouring pause only at packet boundaries.
// Optional: define PKTZ_STAT_EN to add the saturating tx_pkt_cnt output.
module ingress_packetizer #(
    parameter int DEPTH      = 256,  // data FIFO words, power of 2, >= MAX_LEN
    parameter int MAX_LEN    = 255,  // max payload words, <= 255
    parameter int DESC_DEPTH = 4     // committed packets awaiting emission, power of 2
) (
    input  logic                clk,
    input  logic                rst_n,
    ingress_packetizer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int DW = $clog2(DESC_DEPTH);

    localparam logic [AW:0] DATA_FULL = (AW+1)'(DEPTH);
    localparam logic [DW:0] DESC_FULL = (DW+1)'(DESC_DEPTH);
    localparam logic [DW:0] DESC_ONE  = (DW+1)'(1);
    localparam logic [AW:0] PTR_ONE   = (AW+1)'(1);
    localparam logic [8:0]  MAX_LEN_W = 9'(MAX_LEN);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_SOP  = 3'd1;
    localparam logic [2:0] ST_HDR  = 3'd2;
    localparam logic [2:0] ST_DATA = 3'd3;
    localparam logic [2:0] ST_EOP  = 3'd4;

    // Storage: payload words and {len, prio, dest} descriptors.
    logic [15:0] data_mem [DEPTH];
    logic [11:0] desc_mem [DESC_DEPTH];

    // Ingress state: speculative and committed write pointers, running length.
    logic [AW:0] wr_spec_q, wr_spec_d;
    logic [AW:0] wr_cmt_q,  wr_cmt_d;
    logic [DW:0] desc_wr_q, desc_wr_d;
    logic [8:0]  len_q,     len_d;
    logic [1:0]  dest_q,    dest_d;
    logic [1:0]  prio_q,    prio_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;
    logic        in_ready_q, in_ready_d;

    // Egress state.
    logic [2:0]  state_q,   state_d;
    logic [AW:0] rd_q,      rd_d;
    logic [DW:0] desc_rd_q, desc_rd_d;
    logic [7:0]  beat_q,    beat_d;
    logic        wr_sop_q,  wr_vld_q, wr_eop_q;
    logic [15:0] wr_data_q, wr_data_d;
`ifdef PKTZ_STAT_EN
    logic [15:0] tx_pkt_cnt_q;
`endif

    logic        xfer;
    logic        word_fits;
    logic        push;
    logic [7:0]  pkt_len;
    logic [1:0]  pkt_dest;
    logic [1:0]  pkt_prio;
    logic [DW:0] desc_cnt;
    logic [11:0] desc_head;
    logic [AW:0] data_used_d;
    logic [DW:0] desc_cnt_d;

    assign xfer      = bus.in_valid & in_ready_q;
    // A word past MAX_LEN is swallowed without taking a FIFO slot.
    assign word_fits = (len_q < MAX_LEN_W);
    assign push      = xfer & bus.in_last & word_fits;
    assign pkt_len   = len_q[7:0] + 8'd1;
    assign pkt_dest  = (len_q == 9'd0) ? bus.in_dest : dest_q;
    assign pkt_prio  = (len_q == 9'd0) ? bus.in_prio : prio_q;
    assign desc_cnt  = desc_wr_q - desc_rd_q;
    assign desc_head = desc_mem[desc_rd_q[DW-1:0]];

    // Ingress next state: speculative write, commit on a legal last, rewind on drop.
    always_comb begin
        // NOTE: every signal gets a default before the branches so no latch is inferred.
        wr_spec_d  = wr_spec_q;
        wr_cmt_d   = wr_cmt_q;
        desc_wr_d  = desc_wr_q;
        len_d      = len_q;
        dest_d     = dest_q;
        prio_d     = prio_q;
        drop_cnt_d = drop_cnt_q;
        if (xfer) begin
            if (len_q == 9'd0) begin
                dest_d = bus.in_dest;
                prio_d = bus.in_prio;
            end
            if (word_fits) begin
                wr_spec_d = wr_spec_q + PTR_ONE;
                len_d     = len_q + 9'd1;
            end
            if (bus.in_last) begin
                len_d = 9'd0;
                if (word_fits) begin
                    wr_cmt_d  = wr_spec_q + PTR_ONE;
                    desc_wr_d = desc_wr_q + DESC_ONE;
                end else begin
                    wr_spec_d = wr_cmt_q;
                    if (drop_cnt_q != 16'hFFFF) begin
                        drop_cnt_d = drop_cnt_q + 16'd1;
                    end
                end
            end
        end
    end

    // Egress next state: IDLE -> SOP -> HDR -> DATA x L -> EOP, pop at EOP.
    always_comb begin
        state_d   = state_q;
        rd_d      = rd_q;
        desc_rd_d = desc_rd_q;
        beat_d    = beat_q;
        case (state_q)
            ST_IDLE: begin
                if ((desc_cnt != '0) && !bus.pause) begin
                    state_d = ST_SOP;
                end
            end
            ST_SOP: begin
                state_d = ST_HDR;
            end
            ST_HDR: begin
                state_d = ST_DATA;
                beat_d  = desc_head[11:4] - 8'd1;
                rd_d    = rd_q + PTR_ONE;
            end
            ST_DATA: begin
                if (beat_q == 8'd0) begin
                    state_d = ST_EOP;
                end else begin
                    beat_d = beat_q - 8'd1;
                    rd_d   = rd_q + PTR_ONE;
                end
            end
            ST_EOP: begin
                desc_rd_d = desc_rd_q + DESC_ONE;
                // The descriptor being popped does not count toward the next packet.
                state_d   = ((desc_cnt > DESC_ONE) && !bus.pause) ? ST_SOP : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output word for the upcoming cycle; the payload read is asynchronous so it
    // lands in the output register in the same cycle wr_vld rises.
    always_comb begin
        wr_data_d = 16'h0000;
        if (state_d == ST_HDR) begin
            wr_data_d = {4'h0, desc_head};
        end else if (state_d == ST_DATA) begin
            wr_data_d = data_mem[rd_q[AW-1:0]];
        end
    end

    // in_ready is registered from the next-cycle occupancy.
    always_comb begin
        data_used_d = wr_spec_d - rd_d;
        desc_cnt_d  = desc_wr_d - desc_rd_d;
        in_ready_d  = ((data_used_d != DATA_FULL) || (len_d >= MAX_LEN_W)) &&
                      (desc_cnt_d != DESC_FULL);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block ordering.
        if (!rst_n) begin
            wr_spec_q  <= '0;
            wr_cmt_q   <= '0;
            desc_wr_q  <= '0;
            len_q      <= '0;
            dest_q     <= '0;
            prio_q     <= '0;
            drop_cnt_q <= '0;
            in_ready_q <= 1'b0;
            state_q    <= ST_IDLE;
            rd_q       <= '0;
            desc_rd_q  <= '0;
            beat_q     <= '0;
            wr_sop_q   <= 1'b0;
            wr_vld_q   <= 1'b0;
            wr_eop_q   <= 1'b0;
            wr_data_q  <= '0;
        end else begin
            wr_spec_q  <= wr_spec_d;
            wr_cmt_q   <= wr_cmt_d;
            desc_wr_q  <= desc_wr_d;
            len_q      <= len_d;
            dest_q     <= dest_d;
            prio_q     <= prio_d;
            drop_cnt_q <= drop_cnt_d;
            in_ready_q <= in_ready_d;
            state_q    <= state_d;
            rd_q       <= rd_d;
            desc_rd_q  <= desc_rd_d;
            beat_q     <= beat_d;
            wr_sop_q   <= (state_d == ST_SOP);
            wr_vld_q   <= (state_d == ST_HDR) || (state_d == ST_DATA);
            wr_eop_q   <= (state_d == ST_EOP);
            wr_data_q  <= wr_data_d;
        end
    end

    // Storage writes: payload words that fit, descriptors on commit.
    always_ff @(posedge clk) begin
        // NOTE: the arrays are not reset; pointers define validity, so stale contents are never read.
        if (xfer && word_fits) begin
            data_mem[wr_spec_q[AW-1:0]] <= bus.in_data;
        end
        if (push) begin
            desc_mem[desc_wr_q[DW-1:0]] <= {pkt_len, pkt_prio, pkt_dest};
        end
    end

`ifdef PKTZ_STAT_EN
    // Emitted-packet counter, one per EOP cycle, saturating.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_pkt_cnt_q <= '0;
        end else if ((state_d == ST_EOP) && (tx_pkt_cnt_q != 16'hFFFF)) begin
            tx_pkt_cnt_q <= tx_pkt_cnt_q + 16'd1;
        end
    end

    assign bus.tx_pkt_cnt = tx_pkt_cnt_q;
`endif

    assign bus.in_ready = in_ready_q;
    assign bus.wr_sop   = wr_sop_q;
    assign bus.wr_vld   = wr_vld_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.wr_eop   = wr_eop_q;
    assign bus.drop_cnt = drop_cnt_q;
endmodule

// File: tb/tb_ingress_packetizer.sv
// tb_ingress_packetizer: directed bench for ingress_packetizer with hand-computed
// headers and payloads; a negedge monitor logs the switch-side framing.
module tb_ingress_packetizer;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    ingress_packetizer_if bus ();

    ingress_packetizer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int viol     = 0;
    int last_xfer_cyc = 0;
    int stall_cnt     = 0;

    logic [15:0] rx_q  [$];
    logic [15:0] exp_q [$];
    int          sop_cyc [$];
    int          eop_cyc [$];

    always @(posedge clk) cyc <= cyc + 1;

    // Switch-side monitor; two strobes in one cycle count as a framing violation.
    always @(negedge clk) begin
        if (bus.wr_vld) rx_q.push_back(bus.wr_data);
        if (bus.wr_sop) sop_cyc.push_back(cyc);
        if (bus.wr_eop) eop_cyc.push_back(cyc);
        if ((bus.wr_sop & bus.wr_vld) | (bus.wr_sop & bus.wr_eop) | (bus.wr_vld & bus.wr_eop))
            viol++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        rx_q.delete();
        sop_cyc.delete();
        eop_cyc.delete();
        exp_q.delete();
    endtask

    // Offer one word from a negedge; returns at the negedge after its transfer.
    task automatic send_word(input logic [15:0] d, input logic last,
                             input logic [1:0] dest, input logic [1:0] prio);
        int w = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        bus.in_dest  = dest;
        bus.in_prio  = prio;
        while (!bus.in_ready && w < 400) begin
            @(negedge clk);
            w++;
        end
        if (!bus.in_ready) check("in_ready_timeout", 32'(bus.in_ready), 32'd1);
        stall_cnt    += w;
        last_xfer_cyc = cyc;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic send_pkt(input int len, input int base,
                            input logic [1:0] dest, input logic [1:0] prio);
        for (int i = 0; i < len; i++)
            send_word(16'(base + i), (i == len - 1), dest, prio);
    endtask

    task automatic wait_eops(input string tag, input int n);
        int w = 0;
        while (eop_cyc.size() < n && w < 2000) begin
            @(negedge clk);
            w++;
        end
        repeat (2) @(negedge clk);
        check({tag, "_eop_count"}, eop_cyc.size(), n);
    endtask

    task automatic check_words(input string tag);
        check({tag, "_len"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            check($sformatf("%s_w%0d", tag, i), rx_q[i], exp_q[i]);
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_last  = 1'b0;
        bus.in_dest  = '0;
        bus.in_prio  = '0;
        bus.pause    = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_wr_sop",   bus.wr_sop,   0);
        check("rst_wr_vld",   bus.wr_vld,   0);
        check("rst_wr_eop",   bus.wr_eop,   0);
        check("rst_wr_data",  bus.wr_data,  0);
        check("rst_drop_cnt", bus.drop_cnt, 0);
        check("rst_in_ready", bus.in_ready, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_in_ready", bus.in_ready, 1);

        // Single 31-word packet, dest=3 prio=1: header 0x01F7.
        clear_log();
        send_pkt(31, 0, 2'd3, 2'd1);
        wait_eops("single", 1);
        exp_q.push_back(16'h01F7);
        for (int i = 0; i < 31; i++) exp_q.push_back(16'(i));
        check_words("single");
        check("single_sop_count", sop_cyc.size(), 1);
        check("single_span", eop_cyc[0] - sop_cyc[0] + 1, 34);
        check("single_latency_ge2", 32'((sop_cyc[0] - last_xfer_cyc) >= 2), 1);

        // Pause holds a buffered 3-word packet; release gives sop next cycle.
        clear_log();
        bus.pause = 1'b1;
        send_pkt(3, 16'h100, 2'd0, 2'd2);
        repeat (20) @(negedge clk);
        check("pause_no_sop", sop_cyc.size(), 0);
        bus.pause = 1'b0;
        @(negedge clk);
        check("pause_release_sop", bus.wr_sop, 1);
        wait_eops("pause", 1);
        exp_q.push_back(16'h0038);
        exp_q.push_back(16'h0100);
        exp_q.push_back(16'h0101);
        exp_q.push_back(16'h0102);
        check_words("pause");

        // Pause raised during DATA: the packet still completes.
        clear_log();
        send_pkt(8, 16'h200, 2'd3, 2'd0);
        for (int w = 0; w < 100 && rx_q.size() < 3; w++) @(negedge clk);
        bus.pause = 1'b1;
        wait_eops("pause_mid", 1);
        exp_q.push_back(16'h0083);
        for (int i = 0; i < 8; i++) exp_q.push_back(16'(16'h200 + i));
        check_words("pause_mid");
        bus.pause = 1'b0;

        // 256-word packet dropped, then 3-word packet dest=2 prio=0 forwarded.
        clear_log();
        stall_cnt = 0;
        send_pkt(256, 0, 2'd1, 2'd3);
        check("drop_cnt_one", bus.drop_cnt, 1);
        check("drop_no_stall", stall_cnt, 0);
        send_pkt(3, 16'hA0, 2'd2, 2'd0);
        wait_eops("drop", 1);
        check("drop_sop_count", sop_cyc.size(), 1);
        exp_q.push_back(16'h0032);
        exp_q.push_back(16'h00A0);
        exp_q.push_back(16'h00A1);
        exp_q.push_back(16'h00A2);
        check_words("drop");

        // Descriptor backpressure: four 1-word packets fill the descriptor FIFO.
        clear_log();
        bus.pause = 1'b1;
        for (int i = 0; i < 4; i++)
            send_word(16'(16'h40 + i), 1'b1, 2'(i), 2'(i));
        check("desc_full_ready", bus.in_ready, 0);
        fork
            send_word(16'h0055, 1'b1, 2'd1, 2'd2);
            begin
                repeat (5) @(negedge clk);
                check("desc_full_no_sop", sop_cyc.size(), 0);
                check("desc_full_hold", bus.in_ready, 0);
                bus.pause = 1'b0;
            end
        join
        wait_eops("desc", 5);
        exp_q.push_back(16'h0010); exp_q.push_back(16'h0040);
        exp_q.push_back(16'h0015); exp_q.push_back(16'h0041);
        exp_q.push_back(16'h001A); exp_q.push_back(16'h0042);
        exp_q.push_back(16'h001F); exp_q.push_back(16'h0043);
        exp_q.push_back(16'h0019); exp_q.push_back(16'h0055);
        check_words("desc");
        for (int k = 0; k < 3; k++)
            check($sformatf("desc_b2b_%0d", k), sop_cyc[k + 1], eop_cyc[k] + 1);

        // Reset during DATA: outputs clear, buffered packet is lost.
        clear_log();
        send_pkt(20, 16'h300, 2'd0, 2'd0);
        for (int w = 0; w < 100 && rx_q.size() < 5; w++) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_wr_sop",   bus.wr_sop,   0);
        check("midrst_wr_vld",   bus.wr_vld,   0);
        check("midrst_wr_eop",   bus.wr_eop,   0);
        check("midrst_wr_data",  bus.wr_data,  0);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", bus.in_ready, 1);
        check("midrst_drop_cnt", bus.drop_cnt, 0);
        clear_log();
        repeat (5) @(negedge clk);
        check("midrst_no_eop", eop_cyc.size(), 0);
        send_word(16'hBEEF, 1'b1, 2'd2, 2'd3);
        wait_eops("midrst", 1);
        exp_q.push_back(16'h001E);
        exp_q.push_back(16'hBEEF);
        check_words("midrst");

        // New packet's in_last transfers in the EOP cycle of the prior packet.
        clear_log();
        send_pkt(4, 16'h600, 2'd0, 2'd3);
        for (int i = 0; i < 7; i++)
            send_word(16'(16'h700 + i), 1'b0, 2'd1, 2'd1);
        for (int w = 0; w < 100 && !bus.wr_eop; w++) @(negedge clk);
        send_word(16'h0707, 1'b1, 2'd1, 2'd1);
        check("coincide_setup", last_xfer_cyc, eop_cyc[0]);
        wait_eops("coincide", 2);
        exp_q.push_back(16'h004C);
        for (int i = 0; i < 4; i++) exp_q.push_back(16'(16'h600 + i));
        exp_q.push_back(16'h0085);
        for (int i = 0; i < 8; i++) exp_q.push_back(16'(16'h700 + i));
        check_words("coincide");
        repeat (20) @(negedge clk);
        check("coincide_sop_count", sop_cyc.size(), 2);
        check("coincide_eop_count_late", eop_cyc.size(), 2);

        check("framing_violations", viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
